// File: rtl/dmem_axil_pkg.sv
// dmem_axil_pkg
// Shared definitions for the AXI4-Lite data-memory controller:
//   state_t           - controller FSM states
//   grant_t           - one-bit round-robin history (which side won last)
//   RESP_OKAY/SLVERR  - AXI response encodings
//   DEFAULT_MEM_BYTES - default implemented memory size in bytes
package dmem_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEM,
    WR_RESP,
    RD_ADDR,
    RD_WAIT,
    RD_RESP
  } state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEFAULT_MEM_BYTES = 1024;

endpackage

// File: rtl/dmem_axil_ctrl.sv
// dmem_axil_ctrl
// AXI4-Lite slave that sequences a block-RAM data memory with a one-cycle
// registered read latency. One transaction is in flight at a time; reads and
// writes are arbitrated round-robin when both are eligible.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*              AXI4-Lite write address / data / response
//   s_ar*/s_r*                   AXI4-Lite read address / data
//   mem_write, mem_byte_en       memory write enable and byte enables
//   mem_addr, mem_wdata          word-aligned memory address, write data
//   mem_rdata                    memory read data (one cycle after mem_addr)
//
// Every output is a register. Readies are decided one cycle ahead: the
// arbiter runs in IDLE (when no grant is outstanding) and in the cycle a
// response completes, so the winning ready is already high in the following
// IDLE cycle, which is the handshake cycle.
module dmem_axil_ctrl
  import dmem_axil_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              mem_write,
  output logic [3:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // One extra bit so a memory that fills the whole address space still works.
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  state_t state;
  grant_t last_grant;
  logic   wr_oor;
  logic   rd_oor;

  logic              wr_elig;
  logic              rd_elig;
  logic              pick_wr;
  logic              pick_rd;
  logic              arb_en;
  logic              aw_oor;
  logic              ar_oor;
  logic [ADDR_W-1:0] aw_aligned;
  logic [ADDR_W-1:0] ar_aligned;

  always_comb begin
    wr_elig = s_awvalid && s_wvalid;
    rd_elig = s_arvalid;
    // A lone request always wins; on a conflict the side that did not win last.
    pick_wr = wr_elig && (!rd_elig || (last_grant == GRANT_READ));
    pick_rd = rd_elig && !pick_wr;
    arb_en  = ((state == IDLE) && !s_awready && !s_arready) ||
              ((state == WR_RESP) && s_bready) ||
              ((state == RD_RESP) && s_rready);
    aw_oor     = {1'b0, s_awaddr} >= MEM_LIMIT;
    ar_oor     = {1'b0, s_araddr} >= MEM_LIMIT;
    aw_aligned = {s_awaddr[ADDR_W-1:2], 2'b00};
    ar_aligned = {s_araddr[ADDR_W-1:2], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GRANT_READ;
      wr_oor      <= 1'b0;
      rd_oor      <= 1'b0;
      s_awready   <= 1'b0;
      s_wready    <= 1'b0;
      s_arready   <= 1'b0;
      s_bvalid    <= 1'b0;
      s_bresp     <= RESP_OKAY;
      s_rvalid    <= 1'b0;
      s_rresp     <= RESP_OKAY;
      s_rdata     <= 32'h0;
      mem_write   <= 1'b0;
      mem_byte_en <= 4'h0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
    end else begin
      if (arb_en) begin
        s_awready <= pick_wr;
        s_wready  <= pick_wr;
        s_arready <= pick_rd;
        if (pick_wr) begin
          last_grant <= GRANT_WRITE;
        end else if (pick_rd) begin
          last_grant <= GRANT_READ;
        end
      end

      case (state)
        IDLE: begin
          // A ready raised last cycle makes this the handshake cycle. If the
          // master withdrew its valid the grant is simply dropped.
          if (s_awready) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            if (s_awvalid && s_wvalid) begin
              mem_addr    <= aw_aligned;
              mem_wdata   <= s_wdata;
              mem_byte_en <= s_wstrb;
              mem_write   <= !aw_oor;
              wr_oor      <= aw_oor;
              state       <= WR_MEM;
            end
          end else if (s_arready) begin
            s_arready <= 1'b0;
            if (s_arvalid) begin
              mem_addr <= ar_aligned;
              rd_oor   <= ar_oor;
              state    <= RD_ADDR;
            end
          end
        end
        WR_MEM: begin
          mem_write <= 1'b0;
          s_bvalid  <= 1'b1;
          s_bresp   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
          state     <= WR_RESP;
        end
        WR_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_ADDR: begin
          // Memory samples mem_addr at the end of this cycle.
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          s_rdata  <= rd_oor ? 32'h0 : mem_rdata;
          s_rresp  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
          s_rvalid <= 1'b1;
          state    <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_axil_ctrl.sv
// tb_dmem_axil_ctrl
// Self-checking bench for dmem_axil_ctrl: a table of single transactions with
// hand-computed expectations, plus directed sequences for read stall, reset
// during a read, write/read arbitration and AW-without-W. Responses are
// checked through a scoreboard queue filled when stimulus is driven.
module tb_dmem_axil_ctrl;
  import dmem_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  dmem_axil_ctrl #(.ADDR_W(12), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_write(mem_write), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: byte-enabled write, one-cycle registered read.
  logic [31:0] mem_arr [256];
  always @(posedge clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_en[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    mem_rdata <= mem_arr[mem_addr[9:2]];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  typedef struct packed {
    logic        is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  int   rd_done = 0;
  int   wr_done = 0;

  task automatic sb_push(input logic is_rd, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    e.is_rd = is_rd;
    e.resp  = resp;
    e.data  = data;
    sb.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every completed B or R beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (s_bvalid && s_bready) begin
        if (sb.size() == 0) begin
          check("b_sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("txn write resp=%0d cyc=%0d", s_bresp, cyc);
          check("b_kind", {31'd0, e.is_rd}, 32'd0);
          check("b_resp", {30'd0, s_bresp}, {30'd0, e.resp});
          wr_done++;
        end
      end
      if (s_rvalid && s_rready) begin
        if (sb.size() == 0) begin
          check("r_sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("txn read resp=%0d data=0x%08h cyc=%0d", s_rresp, s_rdata, cyc);
          check("r_kind", {31'd0, e.is_rd}, 32'd1);
          check("r_resp", {30'd0, s_rresp}, {30'd0, e.resp});
          check("r_data", s_rdata, e.data);
          rd_done++;
        end
      end
    end
  end

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    int n = 0;
    sb_push(1'b0, er, 32'h0);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    while (!(s_awready && s_wready) && n < 20) begin @(negedge clk); n++; end
    check("wr_grant", {31'd0, s_awready && s_wready}, 32'd1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);  // T+1
    check("wr_mem_write", {31'd0, mem_write}, {31'd0, er == RESP_OKAY});
    check("wr_mem_addr", {20'd0, mem_addr}, {20'd0, a[11:2], 2'b00});
    if (er == RESP_OKAY) begin
      check("wr_byte_en", {28'd0, mem_byte_en}, {28'd0, s});
      check("wr_mem_wdata", mem_wdata, d);
    end
    check("wr_bvalid_early", {31'd0, s_bvalid}, 32'd0);
    @(negedge clk);  // T+2
    check("wr_bvalid", {31'd0, s_bvalid}, 32'd1);
    check("wr_mem_write_end", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [1:0] er, input logic [31:0] ed);
    int n = 0;
    sb_push(1'b1, er, ed);
    s_araddr = a; s_arvalid = 1'b1;
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    check("rd_grant", {31'd0, s_arready}, 32'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);  // T+1
    check("rd_mem_addr", {20'd0, mem_addr}, {20'd0, a[11:2], 2'b00});
    check("rd_rvalid_t1", {31'd0, s_rvalid}, 32'd0);
    @(negedge clk);  // T+2
    check("rd_rvalid_t2", {31'd0, s_rvalid}, 32'd0);
    @(negedge clk);  // T+3
    check("rd_rvalid_t3", {31'd0, s_rvalid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    check(nm, sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        is_wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    logic        kinds[4];
    int          gcyc[4];
    logic        aw_seen;

    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[0] = 32'hA5A5A5A5;
    mem_arr[4] = 32'h12345678;
    mem_arr[8] = 32'h87654321;

    tbl[0]  = '{1'b1, 12'h400, 32'hDEADBEEF, 4'b1111, RESP_SLVERR, 32'h0};
    tbl[1]  = '{1'b0, 12'h400, 32'h0,        4'b0000, RESP_SLVERR, 32'h0};
    tbl[2]  = '{1'b0, 12'h013, 32'h0,        4'b0000, RESP_OKAY,   32'h12345678};
    tbl[3]  = '{1'b1, 12'h010, 32'hAABBCCDD, 4'b0101, RESP_OKAY,   32'h0};
    tbl[4]  = '{1'b0, 12'h010, 32'h0,        4'b0000, RESP_OKAY,   32'h12BB56DD};
    tbl[5]  = '{1'b1, 12'h3FC, 32'hCAFEF00D, 4'b1111, RESP_OKAY,   32'h0};
    tbl[6]  = '{1'b0, 12'h3FF, 32'h0,        4'b0000, RESP_OKAY,   32'hCAFEF00D};
    tbl[7]  = '{1'b1, 12'h020, 32'h11223344, 4'b0000, RESP_OKAY,   32'h0};
    tbl[8]  = '{1'b0, 12'h020, 32'h0,        4'b0000, RESP_OKAY,   32'h87654321};
    tbl[9]  = '{1'b1, 12'hFFC, 32'h01020304, 4'b1111, RESP_SLVERR, 32'h0};
    tbl[10] = '{1'b0, 12'h7FC, 32'h0,        4'b0000, RESP_SLVERR, 32'h0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {18'd0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                         s_bresp, s_rresp, mem_write, mem_byte_en}, 32'd0);
    check("reset_rdata", s_rdata, 32'd0);
    check("reset_mem", {8'd0, mem_addr, 12'd0} | mem_wdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].resp);
      else              do_read(tbl[i].addr, tbl[i].resp, tbl[i].rdata);
    end
    wait_drain("table_drain");

    // Read stall: rdata/rresp held while rready is low.
    s_rready = 1'b0;
    sb_push(1'b1, RESP_OKAY, 32'h12BB56DD);
    s_araddr = 12'h013; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
    check("stall_rvalid_rise", {31'd0, s_rvalid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {s_rvalid, s_rresp, 29'd0} ^ s_rdata, {1'b1, 2'b00, 29'd0} ^ 32'h12BB56DD);
    end
    @(posedge clk); #1;
    s_rready = 1'b1;
    wait_drain("stall_drain");

    // Reset asserted while the read sits in RD_WAIT.
    sb_push(1'b1, RESP_OKAY, 32'h0);
    s_araddr = 12'h010; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;  // now in RD_ADDR
    s_arvalid = 1'b0;
    @(posedge clk); #2;  // now in RD_WAIT
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", {18'd0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                           s_bresp, s_rresp, mem_write, mem_byte_en}, 32'd0);
    check("rst_mid_rdata", s_rdata, 32'd0);
    check("rst_mid_addr", {20'd0, mem_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    if (sb.size() != 0) void'(sb.pop_back());
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s_rvalid) n++;
    end
    check("rst_no_response", n, 32'd0);
    @(posedge clk); #1;
    do_read(12'h3FC, RESP_OKAY, 32'hCAFEF00D);
    wait_drain("rst_drain");

    // Continuous AW+W+AR: grants alternate W,R,W,R starting with W.
    s_awaddr = 12'h040; s_wdata = 32'h55AA55AA; s_wstrb = 4'hF;
    s_araddr = 12'h040;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    g = 0; n = 0;
    while (g < 4 && n < 80) begin
      @(negedge clk); n++;
      if (s_awready && s_wready) begin
        kinds[g] = 1'b0; gcyc[g] = cyc; g++;
        sb_push(1'b0, RESP_OKAY, 32'h0);
      end else if (s_arready) begin
        kinds[g] = 1'b1; gcyc[g] = cyc; g++;
        sb_push(1'b1, RESP_OKAY, 32'h55AA55AA);
      end
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check("arb_grants", g, 32'd4);
    if (g == 4) begin
      for (int k = 0; k < 4; k++) check("arb_order", {31'd0, kinds[k]}, k % 2);
      check("arb_gap_wr", gcyc[1] - gcyc[0], 32'd3);
      check("arb_gap_rd", gcyc[2] - gcyc[1], 32'd4);
    end
    wait_drain("arb_drain");

    // AW without W while AR is valid: read completes, write waits for W.
    n = rd_done;
    s_awaddr = 12'h080; s_wdata = 32'h0F0F0F0F; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b0;
    s_araddr = 12'h010; s_arvalid = 1'b1;
    sb_push(1'b1, RESP_OKAY, 32'h12BB56DD);
    aw_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_awready || s_wready) aw_seen = 1'b1;
      if (s_arready) begin
        @(posedge clk); #1;
        s_arvalid = 1'b0;
      end
    end
    check("aw_only_no_ready", {31'd0, aw_seen}, 32'd0);
    check("aw_only_read_done", rd_done - n, 32'd1);
    @(posedge clk); #1;
    do_write(12'h080, 32'h0F0F0F0F, 4'hF, RESP_OKAY);
    do_read(12'h080, RESP_OKAY, 32'h0F0F0F0F);
    wait_drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
